instruction_decode: RTL and testbench

Decode stage directly downstream of the fetch stage. Consumes the IF/ID pair (instruction_ID, pc_ID) and holds the 32x64 register file, which is written by writeback. Detects load-use hazards and returns pc_stall to fetch. Produces the registered ID/EX pipeline bundle for the execute stage.

---
 rtl/instruction_decode_if.sv | 41 ++++
 rtl/instruction_decode.sv | 167 ++++++++++++++++
 tb/tb_instruction_decode.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/instruction_decode_if.sv
// IF/ID, writeback and ID/EX signal bundle around the decode stage.
// slave: the decode stage itself; master: the surrounding pipeline (or bench).
interface instruction_decode_if #(
    parameter int unsigned DATA_W = 64
);
    logic [31:0]       instruction_ID;
    logic [DATA_W-1:0] pc_ID;
    logic              flush;
    logic              reg_write_WB;
    logic [4:0]        rd_WB;
    logic [DATA_W-1:0] data_WB;

    logic              pc_stall;
    logic [DATA_W-1:0] pc_EX;
    logic [DATA_W-1:0] rdata1_EX;
    logic [DATA_W-1:0] rdata2_EX;
    logic [DATA_W-1:0] imm_EX;
    logic [4:0]        rd_EX;
    logic              reg_write_EX;
    logic              mem_read_EX;
    logic              mem_write_EX;
    logic              mem_to_reg_EX;
    logic              alu_src_EX;
    logic              branch_EX;
    logic              uncond_branch_EX;
    logic [3:0]        alu_ctl_EX;

    modport slave (
        input  instruction_ID, pc_ID, flush, reg_write_WB, rd_WB, data_WB,
        output pc_stall, pc_EX, rdata1_EX, rdata2_EX, imm_EX, rd_EX,
               reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX,
               alu_src_EX, branch_EX, uncond_branch_EX, alu_ctl_EX
    );

    modport master (
        output instruction_ID, pc_ID, flush, reg_write_WB, rd_WB, data_WB,
        input  pc_stall, pc_EX, rdata1_EX, rdata2_EX, imm_EX, rd_EX,
               reg_write_EX, mem_read_EX, mem_write_EX, mem_to_reg_EX,
               alu_src_EX, branch_EX, uncond_branch_EX, alu_ctl_EX
    );
endinterface

// File: rtl/instruction_decode.sv
// LEGv8-subset decode stage: register file, load-use hazard detection, ID/EX register.
// Optional macro WB_BYPASS_EN forwards a same-cycle writeback into the register reads.
module instruction_decode #(
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned NUM_REGS = 32
) (
    input logic                 clk,
    input logic                 resetl,
    instruction_decode_if.slave bus
);
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ORR  = 4'b0001;
    localparam logic [3:0] ALU_PASS = 4'b0111;
    localparam logic [4:0] XZR      = 5'd31;

    logic [31:0] instr;
    logic [10:0] opc;
    logic [4:0]  rn_idx;
    logic [4:0]  r2_idx;

    // Control order: reg_write, mem_read, mem_write, mem_to_reg, alu_src, branch, uncond
    logic [6:0]        ctl;
    logic [3:0]        alu;
    logic [DATA_W-1:0] imm;
    logic              rn_used;
    logic              r2_used;
    logic              r2_is_rm;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;

    logic              hazard;
    logic              bubble;

    logic [DATA_W-1:0] pc_d, pc_q;
    logic [DATA_W-1:0] rdata1_d, rdata1_q;
    logic [DATA_W-1:0] rdata2_d, rdata2_q;
    logic [DATA_W-1:0] imm_d, imm_q;
    logic [4:0]        rd_d, rd_q;
    logic [6:0]        ctl_d, ctl_q;
    logic [3:0]        alu_d, alu_q;

    assign instr  = bus.instruction_ID;
    assign opc    = instr[31:21];
    assign rn_idx = instr[9:5];
    assign r2_idx = r2_is_rm ? instr[20:16] : instr[4:0];

    always_comb begin
        ctl      = 7'b0;
        alu      = ALU_ADD;
        imm      = '0;
        rn_used  = 1'b0;
        r2_used  = 1'b0;
        r2_is_rm = 1'b0;
        if (opc == 11'h7C2) begin
            ctl     = 7'b1101100;
            imm     = {{(DATA_W-9){instr[20]}}, instr[20:12]};
            rn_used = 1'b1;
        end else if (opc == 11'h7C0) begin
            ctl     = 7'b0010100;
            imm     = {{(DATA_W-9){instr[20]}}, instr[20:12]};
            rn_used = 1'b1;
            r2_used = 1'b1;
        end else if (opc == 11'h458 || opc == 11'h658 || opc == 11'h450 || opc == 11'h550) begin
            ctl      = 7'b1000000;
            rn_used  = 1'b1;
            r2_used  = 1'b1;
            r2_is_rm = 1'b1;
            case (opc)
                11'h658: alu = ALU_SUB;
                11'h450: alu = ALU_AND;
                11'h550: alu = ALU_ORR;
                default: alu = ALU_ADD;
            endcase
        end else if (instr[31:24] == 8'hB4) begin
            ctl     = 7'b0000010;
            alu     = ALU_PASS;
            imm     = {{(DATA_W-21){instr[23]}}, instr[23:5], 2'b00};
            rn_used = 1'b1;
            r2_used = 1'b1;
        end else if (instr[31:26] == 6'h05) begin
            ctl = 7'b0000001;
            imm = {{(DATA_W-28){instr[25]}}, instr[25:0], 2'b00};
        end else if (instr[31:23] == 9'h1A5) begin
            ctl = 7'b1000100;
            alu = ALU_PASS;
            imm = DATA_W'(instr[20:5]) << {instr[22:21], 4'b0000};
        end
    end

    always_comb begin
        regs_d = regs_q;
        if (bus.reg_write_WB && bus.rd_WB != XZR) begin
            regs_d[bus.rd_WB] = bus.data_WB;
        end
    end

    always_comb begin
        rdata1 = (rn_idx == XZR) ? '0 : regs_q[rn_idx];
        rdata2 = (r2_idx == XZR) ? '0 : regs_q[r2_idx];
`ifdef WB_BYPASS_EN
        if (bus.reg_write_WB && bus.rd_WB != XZR) begin
            if (bus.rd_WB == rn_idx) rdata1 = bus.data_WB;
            if (bus.rd_WB == r2_idx) rdata2 = bus.data_WB;
        end
`endif
    end

    // ctl_q[5] is mem_read of the instruction currently in EX.
    always_comb begin
        hazard = ctl_q[5] && (rd_q != XZR) &&
                 ((rn_used && rd_q == rn_idx) || (r2_used && rd_q == r2_idx));
        bubble = bus.flush || hazard;
    end

    assign bus.pc_stall = hazard && !bus.flush && !resetl;

    always_comb begin
        pc_d     = bus.pc_ID;
        rdata1_d = rdata1;
        rdata2_d = rdata2;
        imm_d    = imm;
        rd_d     = instr[4:0];
        ctl_d    = bubble ? 7'b0 : ctl;
        alu_d    = bubble ? ALU_ADD : alu;
    end

    always_ff @(posedge clk) begin
        if (resetl) begin
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            pc_q     <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            rd_q     <= '0;
            ctl_q    <= '0;
            alu_q    <= '0;
        end else begin
            regs_q   <= regs_d;
            pc_q     <= pc_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
            imm_q    <= imm_d;
            rd_q     <= rd_d;
            ctl_q    <= ctl_d;
            alu_q    <= alu_d;
        end
    end

    assign bus.pc_EX            = pc_q;
    assign bus.rdata1_EX        = rdata1_q;
    assign bus.rdata2_EX        = rdata2_q;
    assign bus.imm_EX           = imm_q;
    assign bus.rd_EX            = rd_q;
    assign bus.reg_write_EX     = ctl_q[6];
    assign bus.mem_read_EX      = ctl_q[5];
    assign bus.mem_write_EX     = ctl_q[4];
    assign bus.mem_to_reg_EX    = ctl_q[3];
    assign bus.alu_src_EX       = ctl_q[2];
    assign bus.branch_EX        = ctl_q[1];
    assign bus.uncond_branch_EX = ctl_q[0];
    assign bus.alu_ctl_EX       = alu_q;
endmodule

// File: tb/tb_instruction_decode.sv
// Directed, table-driven bench for instruction_decode; one table row per clock cycle.
// Expected ORR-bypass data follows WB_BYPASS_EN.
module tb_instruction_decode;
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LD   = 7'b1101100;
    localparam logic [6:0] C_ST   = 7'b0010100;
    localparam logic [6:0] C_R    = 7'b1000000;
    localparam logic [6:0] C_MOVZ = 7'b1000100;
    localparam logic [6:0] C_CBZ  = 7'b0000010;
    localparam logic [6:0] C_B    = 7'b0000001;
    localparam logic [3:0] A_ADD  = 4'b0010;
    localparam logic [3:0] A_SUB  = 4'b0110;
    localparam logic [3:0] A_AND  = 4'b0000;
    localparam logic [3:0] A_ORR  = 4'b0001;
    localparam logic [3:0] A_PASS = 4'b0111;
    localparam logic [63:0] M8    = 64'hFFFF_FFFF_FFFF_FFF8;
    localparam logic [63:0] M4    = 64'hFFFF_FFFF_FFFF_FFFC;
`ifdef WB_BYPASS_EN
    localparam logic [63:0] BYP_X7 = 64'd9;
`else
    localparam logic [63:0] BYP_X7 = 64'd0;
`endif

    localparam logic [31:0] I_ADD   = 32'h8B020023;
    localparam logic [31:0] I_LDUR  = 32'hF85F8024;
    localparam logic [31:0] I_SUB   = 32'hCB010085;
    localparam logic [31:0] I_MOVZ  = 32'hD2A24686;
    localparam logic [31:0] I_CBZ   = 32'hB4FFFFE6;
    localparam logic [31:0] I_ORRZ  = 32'hAA1F03EA;
    localparam logic [31:0] I_ORR7  = 32'hAA0700E8;

    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic [63:0] pc;
        logic        flush;
        logic        wb_en;
        logic [4:0]  wb_rd;
        logic [63:0] wb_data;
        logic        stall;
        logic [63:0] e_pc;
        logic [63:0] e_r1;
        logic [63:0] e_r2;
        logic [63:0] e_imm;
        logic [4:0]  e_rd;
        logic [6:0]  e_ctl;
        logic [3:0]  e_alu;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    logic resetl;
    always #5 clk = ~clk;

    instruction_decode_if #(.DATA_W(64)) bus ();

    instruction_decode #(.DATA_W(64), .NUM_REGS(32)) dut (
        .clk   (clk),
        .resetl(resetl),
        .bus   (bus)
    );

    task automatic add(input logic rst, input logic [31:0] instr, input logic [63:0] pc,
                       input logic flush, input logic wb_en, input logic [4:0] wb_rd,
                       input logic [63:0] wb_data, input logic stall, input logic [63:0] e_pc,
                       input logic [63:0] e_r1, input logic [63:0] e_r2,
                       input logic [63:0] e_imm, input logic [4:0] e_rd,
                       input logic [6:0] e_ctl, input logic [3:0] e_alu);
        vec_t v;
        v.rst = rst; v.instr = instr; v.pc = pc; v.flush = flush;
        v.wb_en = wb_en; v.wb_rd = wb_rd; v.wb_data = wb_data; v.stall = stall;
        v.e_pc = e_pc; v.e_r1 = e_r1; v.e_r2 = e_r2; v.e_imm = e_imm;
        v.e_rd = e_rd; v.e_ctl = e_ctl; v.e_alu = e_alu;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic [31:0] instr, input logic [63:0] pc,
                         input logic flush, input logic wb_en, input logic [4:0] wb_rd,
                         input logic [63:0] wb_data);
        resetl             = rst;
        bus.instruction_ID = instr;
        bus.pc_ID          = pc;
        bus.flush          = flush;
        bus.reg_write_WB   = wb_en;
        bus.rd_WB          = wb_rd;
        bus.data_WB        = wb_data;
    endtask

    function automatic logic [6:0] got_ctl();
        return {bus.reg_write_EX, bus.mem_read_EX, bus.mem_write_EX, bus.mem_to_reg_EX,
                bus.alu_src_EX, bus.branch_EX, bus.uncond_branch_EX};
    endfunction

    task automatic check_bit(input string name, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, got, exp);
        end
    endtask

    task automatic check_ex(input string name, input vec_t v);
        logic [271:0] got;
        logic [271:0] exp;
        got = {bus.pc_EX, bus.rdata1_EX, bus.rdata2_EX, bus.imm_EX, bus.rd_EX, got_ctl(),
               bus.alu_ctl_EX};
        exp = {v.e_pc, v.e_r1, v.e_r2, v.e_imm, v.e_rd, v.e_ctl, v.e_alu};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc/r1/r2/imm/rd/ctl/alu=%h expected %h", name, got, exp);
        end
    endtask

    initial begin
        int stalls;
        logic done;
        drive(1'b1, 32'h0, 64'h0, 1'b0, 1'b0, 5'd0, 64'h0);

        //  rst instr        pc     fl wb rd   data   st  e_pc   e_r1 e_r2    e_imm        rd   ctl     alu
        add(1, 32'h0,        'h0,   0, 0, 0,   'h0,   0,  'h0,   0,   0,      0,           0,   C_NONE, 4'b0000);
        add(0, 32'h0,        'h0,   0, 0, 0,   'h0,   0,  'h0,   0,   0,      0,           0,   C_NONE, A_ADD);
        add(0, 32'h0,        'h0,   0, 1, 1,   'h5,   0,  'h0,   0,   0,      0,           0,   C_NONE, A_ADD);
        add(0, 32'h0,        'h0,   0, 1, 2,   'h7,   0,  'h0,   0,   0,      0,           0,   C_NONE, A_ADD);
        add(0, I_ADD,        'h10,  0, 0, 0,   'h0,   0,  'h10,  5,   7,      0,           3,   C_R,    A_ADD);
        add(0, I_LDUR,       'h14,  0, 0, 0,   'h0,   0,  'h14,  5,   0,      M8,          4,   C_LD,   A_ADD);
        add(0, I_SUB,        'h18,  0, 0, 0,   'h0,   1,  'h18,  0,   5,      0,           5,   C_NONE, A_ADD);
        add(0, I_SUB,        'h18,  0, 0, 0,   'h0,   0,  'h18,  0,   5,      0,           5,   C_R,    A_SUB);
        add(0, I_LDUR,       'h1c,  0, 0, 0,   'h0,   0,  'h1c,  5,   0,      M8,          4,   C_LD,   A_ADD);
        add(0, I_SUB,        'h20,  1, 1, 6,   'h55,  0,  'h20,  0,   5,      0,           5,   C_NONE, A_ADD);
        add(0, I_MOVZ,       'h24,  0, 0, 0,   'h0,   0,  'h24,  0,   'h55,   'h12340000,  6,   C_MOVZ, A_PASS);
        add(0, I_CBZ,        'h28,  0, 0, 0,   'h0,   0,  'h28,  0,   'h55,   M4,          6,   C_CBZ,  A_PASS);
        add(0, 32'h0,        'h0,   0, 1, 31,  'hFF,  0,  'h0,   0,   0,      0,           0,   C_NONE, A_ADD);
        add(0, I_ORRZ,       'h2c,  0, 1, 31,  'hFF,  0,  'h2c,  0,   0,      0,           10,  C_R,    A_ORR);
        add(0, I_ORR7,       'h30,  0, 1, 7,   'h9,   0,  'h30,  BYP_X7, BYP_X7, 0,        8,   C_R,    A_ORR);
        add(0, I_ORR7,       'h34,  0, 0, 0,   'h0,   0,  'h34,  9,   9,      0,           8,   C_R,    A_ORR);
        add(0, 32'hF8010022, 'h38,  0, 0, 0,   'h0,   0,  'h38,  5,   7,      16,          2,   C_ST,   A_ADD);
        add(0, 32'h8A020029, 'h3c,  0, 0, 0,   'h0,   0,  'h3c,  5,   7,      0,           9,   C_R,    A_AND);
        add(0, 32'h17FFFFFF, 'h40,  0, 0, 0,   'h0,   0,  'h40,  0,   0,      M4,          31,  C_B,    A_ADD);
        add(0, 32'hF8400029, 'h44,  0, 0, 0,   'h0,   0,  'h44,  5,   0,      0,           9,   C_LD,   A_ADD);
        add(0, 32'hF8000049, 'h48,  0, 0, 0,   'h0,   1,  'h48,  7,   0,      0,           9,   C_NONE, A_ADD);
        add(0, 32'hF840003F, 'h4c,  0, 0, 0,   'h0,   0,  'h4c,  5,   0,      0,           31,  C_LD,   A_ADD);
        add(0, I_ORRZ,       'h50,  0, 0, 0,   'h0,   0,  'h50,  0,   0,      0,           10,  C_R,    A_ORR);
        add(0, I_LDUR,       'h54,  0, 0, 0,   'h0,   0,  'h54,  5,   0,      M8,          4,   C_LD,   A_ADD);
        add(0, 32'h14000080, 'h58,  0, 0, 0,   'h0,   0,  'h58,  0,   0,      'h200,       0,   C_B,    A_ADD);
        add(0, I_LDUR,       'h5c,  0, 0, 0,   'h0,   0,  'h5c,  5,   0,      M8,          4,   C_LD,   A_ADD);
        add(1, I_SUB,        'h60,  0, 0, 0,   'h0,   0,  'h0,   0,   0,      0,           0,   C_NONE, 4'b0000);
        add(0, I_ADD,        'h64,  0, 0, 0,   'h0,   0,  'h64,  0,   0,      0,           3,   C_R,    A_ADD);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].rst, vecs[i].instr, vecs[i].pc, vecs[i].flush, vecs[i].wb_en,
                  vecs[i].wb_rd, vecs[i].wb_data);
            #1;
            check_bit($sformatf("vec%0d stall", i), bus.pc_stall, vecs[i].stall);
            @(posedge clk);
            #1;
            check_ex($sformatf("vec%0d idex", i), vecs[i]);
        end

        // Load-use: hold SUB in ID until the stall clears, bounded to four cycles.
        @(negedge clk);
        drive(1'b0, I_LDUR, 64'h80, 1'b0, 1'b0, 5'd0, 64'h0);
        @(posedge clk);
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 4 && !done; c++) begin
            @(negedge clk);
            drive(1'b0, I_SUB, 64'h84, 1'b0, 1'b0, 5'd0, 64'h0);
            #1;
            if (bus.pc_stall) stalls++;
            else done = 1'b1;
            @(posedge clk);
        end
        check_bit("stall_seq terminated", done, 1'b1);
        n_vec++;
        if (stalls != 1) begin
            n_bad++;
            $display("FAIL stall_seq count: got %0d expected 1", stalls);
        end
        #1;
        n_vec++;
        if (got_ctl() !== C_R || bus.alu_ctl_EX !== A_SUB || bus.rd_EX !== 5'd5) begin
            n_bad++;
            $display("FAIL stall_seq issue: got ctl=%b alu=%b rd=%0d expected ctl=%b alu=%b rd=5",
                     got_ctl(), bus.alu_ctl_EX, bus.rd_EX, C_R, A_SUB);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
